// File: rtl/ssd_entry_pkg.sv
// Shared types and constants for the two-digit keypad entry / SSD display block.
package ssd_entry_pkg;

    // Key press filter states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } filt_state_t;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // chip_sel encoding: 0 drives the right (ones) digit, 1 the left (tens) digit.
    localparam logic SEL_ONES = 1'b0;
    localparam logic SEL_TENS = 1'b1;

endpackage

// File: rtl/disp_ctrl.sv
// Hex nibble to seven-segment decode. Active-high segments, seg_out = {g,f,e,d,c,b,a}.
module disp_ctrl (
    input  logic [3:0] disp_val,
    output logic [6:0] seg_out
);

    // Pure lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        seg_out = 7'b0000000;
        case (disp_val)
            4'h0: seg_out = 7'b0111111;
            4'h1: seg_out = 7'b0000110;
            4'h2: seg_out = 7'b1011011;
            4'h3: seg_out = 7'b1001111;
            4'h4: seg_out = 7'b1100110;
            4'h5: seg_out = 7'b1101101;
            4'h6: seg_out = 7'b1111101;
            4'h7: seg_out = 7'b0000111;
            4'h8: seg_out = 7'b1111111;
            4'h9: seg_out = 7'b1101111;
            4'hA: seg_out = 7'b1110111;
            4'hB: seg_out = 7'b1111100;
            4'hC: seg_out = 7'b0111001;
            4'hD: seg_out = 7'b1011110;
            4'hE: seg_out = 7'b1111001;
            4'hF: seg_out = 7'b1110001;
            default: seg_out = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/key_press_filter.sv
// Turns the decoder's key_valid/key_code level into one strobe per physical press.
// A press must hold the same code for STABLE_CYCLES cycles after the first sample,
// and a release must stay low just as long before another press is looked at.
// new_key is a combinational strobe, high during the cycle whose closing edge
// accepts the press; new_code is the latched candidate code.
module key_press_filter
    import ssd_entry_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       new_key,
    output logic [3:0] new_code
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    filt_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;

    // State, debounce counter and candidate code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next-state logic and accept strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        new_key = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = PRESS_DB;
                    cand_d  = key_code;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                // A drop or a different code aborts; the aborting sample is not reused.
                if (!key_valid || key_code != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    new_key = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Code changes while held are deliberately ignored.
                if (!key_valid) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
            end
            REL_DB: begin
                if (key_valid) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign new_code = cand_q;

endmodule

// File: rtl/ssd_two_digit_entry.sv
// Two-digit hex entry from a keypad with a self-refreshing dual-digit SSD.
// Each accepted press shifts a nibble into {tens, ones}; the display alternates
// between the digits every REFRESH_CYCLES cycles and blanks a digit not yet entered.
module ssd_two_digit_entry
    import ssd_entry_pkg::*;
#(
    parameter int CLK_FREQ       = 125_000_000,
    parameter int STABLE_CYCLES  = 1_250_000,
    parameter int REFRESH_CYCLES = 125_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       new_key,
    output logic [7:0] digits,
    output logic [1:0] digits_vld,
    output logic [6:0] seg,
    output logic       chip_sel
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_CYCLES - 1);

    // Parameter sanity at elaboration time.
    if (CLK_FREQ <= 0) begin : g_bad_clk
        $error("CLK_FREQ must be positive");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be at least 2");
    end

    logic          accept;
    logic [3:0]    accept_code;
    logic          new_key_q;
    logic [7:0]    digits_q, digits_d;
    logic [1:0]    vld_q, vld_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          sel_q, sel_d;
    logic [3:0]    sel_nib;
    logic          sel_vld;
    logic [6:0]    dec_seg;

    key_press_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .key_code (key_code),
        .key_valid(key_valid),
        .new_key  (accept),
        .new_code (accept_code)
    );

    // Entry shift register next value: newest digit enters on the right.
    always_comb begin
        digits_d = digits_q;
        vld_d    = vld_q;
        if (accept) begin
            digits_d = {digits_q[3:0], accept_code};
            vld_d    = {vld_q[0], 1'b1};
        end
    end

    // Refresh counter next value; chip_sel flips on each wrap.
    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        sel_d  = sel_q;
        if (rcnt_q == RCNT_LAST) begin
            rcnt_d = '0;
            sel_d  = ~sel_q;
        end
    end

    // Entry register, new_key pulse and display refresh state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_key_q <= 1'b0;
            digits_q  <= 8'h00;
            vld_q     <= 2'b00;
            rcnt_q    <= '0;
            sel_q     <= SEL_ONES;
        end else begin
            new_key_q <= accept;
            digits_q  <= digits_d;
            vld_q     <= vld_d;
            rcnt_q    <= rcnt_d;
            sel_q     <= sel_d;
        end
    end

    // Select the displayed nibble straight from the registers so seg adds no latency.
    always_comb begin
        sel_nib = digits_q[3:0];
        sel_vld = vld_q[0];
        if (sel_q == SEL_TENS) begin
            sel_nib = digits_q[7:4];
            sel_vld = vld_q[1];
        end
    end

    disp_ctrl u_disp (
        .disp_val(sel_nib),
        .seg_out (dec_seg)
    );

    assign seg        = sel_vld ? dec_seg : SEG_BLANK;
    assign new_key    = new_key_q;
    assign digits     = digits_q;
    assign digits_vld = vld_q;
    assign chip_sel   = sel_q;

endmodule

// File: doc/ssd_two_digit_entry.md
# ssd_two_digit_entry

Downstream consumer of the keypad decoder's `DecodeOut` / `is_a_key_pressed` pair. It qualifies each physical key press into exactly one event and shifts accepted hex digits into a two-digit entry register. It also time-multiplexes both digits onto the dual-digit SSD through `chip_sel`, replacing the manual button-toggled digit select.

## Interface
Parameters:
- `CLK_FREQ`, 125_000_000: system clock in Hz; informational only.
- `STABLE_CYCLES`, 1_250_000: cycles (10 ms) a press or release must persist before it is accepted; must be ≥ 1.
- `REFRESH_CYCLES`, 125_000: cycles each digit is displayed before `chip_sel` toggles (1 ms); must be ≥ 2.

Ports:
- `clk`, input, 1: system clock; all state on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `key_code`, input, 4: decoded key value from the keypad decoder.
- `key_valid`, input, 1: high while the decoder reports a key held.
- `new_key`, output, 1: one-cycle pulse when a press is accepted.
- `digits`, output, 8: entry register, `{tens, ones}`.
- `digits_vld`, output, 2: bit 0 is ones valid, bit 1 is tens valid.
- `seg`, output, 7: segment drive for the currently selected digit.
- `chip_sel`, output, 1: 0 selects the right digit (ones), 1 selects the left digit (tens).

## Operation
Press filter FSM, states IDLE, PRESS_DB, HELD, REL_DB:
- IDLE: `key_valid`=1 → PRESS_DB; latch `key_code` into `cand`; `cnt`=0.
- PRESS_DB:
  - `key_valid`=0 or `key_code`≠`cand` → IDLE.
  - Else if `cnt`=STABLE_CYCLES-1 → HELD and assert `new_key` with `cand`.
  - Else `cnt`+1.
- HELD: `key_valid`=0 → REL_DB; `cnt`=0. Code changes while held are ignored, so no second event is produced.
- REL_DB:
  - `key_valid`=1 → HELD, with no event.
  - `cnt`=STABLE_CYCLES-1 → IDLE.
  - Else `cnt`+1.

Entry register:
- On an accepted press, `digits` ← `{digits[3:0], cand}` and `digits_vld` ← `{digits_vld[0], 1}`.
- All 16 codes are data; there are no command keys.
- Entries beyond two discard the old tens digit.

Display mux:
- `rcnt` counts 0..REFRESH_CYCLES-1 and wraps to 0; `chip_sel` toggles on each wrap.
- `seg` is a combinational decode of the selected nibble through the existing `disp_ctrl` mapping.
- `seg`=7'b0000000 (blank) when the selected digit's `digits_vld` bit is 0.

## Timing
Reset values:
- State IDLE; `cnt`, `rcnt`, `digits`, `digits_vld`, `new_key`, `chip_sel` all 0.
- Therefore `seg`=0, blank.

Latencies:
- Press latency: if `key_valid` is first sampled high at edge E, `new_key` goes high after edge E+STABLE_CYCLES for exactly one cycle.
- `digits` and `digits_vld` update on that same edge.
- A press shorter than STABLE_CYCLES samples produces no event.
- Release must be stable STABLE_CYCLES cycles before the next press can be detected.

Display timing:
- `chip_sel` period is 2·REFRESH_CYCLES cycles with a 50% duty.
- `seg` has no added latency relative to `chip_sel`, `digits` or `digits_vld`.

Boundary conditions:
- Accepted press coinciding with a `rcnt` wrap: both take effect on the same edge. `seg` shows the new digit under the new `chip_sel`.
- `rst` mid-debounce or mid-display: immediate return to reset values. The press in progress is lost, with no `new_key`.
- Key held through reset release: behaves as a fresh press measured from the first sampled edge.

## Structure
Package `ssd_entry_pkg` holds:
- `filt_state_t` enum (IDLE, PRESS_DB, HELD, REL_DB).
- `SEG_BLANK` = 7'b0.
- `SEL_ONES`=1'b0 and `SEL_TENS`=1'b1.

One sub-module, `key_press_filter`:
- Contains the FSM, `cnt` and `cand`.
- Ports: `clk`, `rst`, `key_code`, `key_valid`, `new_key`, `new_code`.

The top contains:
- The entry register.
- The refresh counter.
- A `disp_ctrl` instance for segment decode.

## Test plan
Simulate with STABLE_CYCLES=4, REFRESH_CYCLES=8.
- Reset release, no keys → `seg`=0 and `digits_vld`=00 throughout; `chip_sel` toggles every 8 cycles, starting at 0.
- `key_code`=5, `key_valid` held 20 cycles → a single `new_key` 4 cycles after first sample; `digits`=8'h05, `digits_vld`=01. `seg` equals `disp_ctrl(5)` when `chip_sel`=0 and is blank when `chip_sel`=1.
- Press 5, release 6 cycles, then press A → `digits`=8'h5A, `digits_vld`=11; `seg` alternates `disp_ctrl(A)` / `disp_ctrl(5)`.
- `key_valid` pulses of 3 cycles, plus a code change 5→7 at cycle 2 of a press → no `new_key`, `digits` unchanged.
- Bouncing release (low 2 cycles, high 1 cycle, low 10 cycles) → no extra event; the next press after a full release is accepted. Third entry 3 after 5,A → `digits`=8'hA3.
- Assert `rst` during PRESS_DB and again when `rcnt`=5 → all outputs return to reset values asynchronously; no `new_key`.
